// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, single-outstanding instruction memory fetch and a small {pc, instruction} FIFO.
// Redirects flush the FIFO; a response still in flight at redirect time is dropped via the discard flag.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_misaligned,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instruction,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nx;
    logic            discard, discard_nx;
    logic [AW:0]     count, count_nx;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [XLEN-1:0] pc_mem [BUF_DEPTH];
    logic [XLEN-1:0] ins_mem [BUF_DEPTH];
    logic            push, pop;

    assign o_mem_req     = state == REQ;
    assign o_mem_addr    = fetch_pc;
    assign o_valid       = count != '0;
    assign o_instruction = ins_mem[rd_ptr];
    assign o_pc          = pc_mem[rd_ptr];
    assign pop           = o_valid && i_ready;
    assign push          = state == WAIT && i_mem_rvalid && !discard && !i_redirect;
    assign count_nx      = count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        discard_nx  = discard;
        if (i_redirect) begin
            fetch_pc_nx = {i_redirect_pc[XLEN-1:2], 2'b00};
            // a grant this cycle or an unanswered request leaves a response to swallow
            if ((state == WAIT && !i_mem_rvalid) || (state == REQ && i_mem_gnt)) begin
                state_nx   = WAIT;
                discard_nx = 1'b1;
            end else begin
                state_nx   = REQ;
                discard_nx = 1'b0;
            end
        end else begin
            case (state)
                IDLE: state_nx = count < DEPTH ? REQ : IDLE;
                REQ:  state_nx = i_mem_gnt ? WAIT : REQ;
                WAIT: if (i_mem_rvalid) begin
                    discard_nx = 1'b0;
                    if (discard) begin
                        state_nx = IDLE;
                    end else begin
                        fetch_pc_nx = fetch_pc + XLEN'(4);
                        state_nx    = count_nx < DEPTH ? REQ : IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            discard      <= 1'b0;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            o_misaligned <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end
        end else begin
            state        <= state_nx;
            fetch_pc     <= fetch_pc_nx;
            discard      <= discard_nx;
            o_misaligned <= i_redirect && i_redirect_pc[1:0] != 2'b00;
            if (i_redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_nx;
                if (push) begin
                    pc_mem[wr_ptr]  <= fetch_pc;
                    ins_mem[wr_ptr] <= i_mem_rdata;
                    wr_ptr          <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: memory responder model plus a queue scoreboard of expected {pc, instruction} pairs.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, mem_req, mem_gnt, mem_rvalid, redirect, misaligned, valid, ready;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, instruction, pc;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .i_clk(clk), .i_reset(rst), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_misaligned(misaligned),
        .o_valid(valid), .o_instruction(instruction), .o_pc(pc), .i_ready(ready)
    );

    typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
    typedef struct {logic [31:0] tgt; int dly; int skip; logic mis; logic [31:0] pc0;} row_t;

    exp_t        q[$];
    row_t        rows[5];
    int          tests = 0, fails = 0;
    int          delay = 1, busy = 0, wcnt = 0, grants = 0, n;
    logic [31:0] paddr;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] a);
        q.push_back('{a, word(a)});
    endtask

    // one clock: score any pop, then advance the memory model and drive gnt/rvalid for the new cycle
    task automatic cycle();
        logic        took;
        logic [31:0] a;
        exp_t        e;
        took = mem_gnt && mem_req;
        a    = mem_addr;
        if (valid && ready && !redirect && !rst) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_pop: pc %h emitted, none expected", pc);
            end else begin
                e = q.pop_front();
                chk("pop_pc", pc, e.pc);
                chk("pop_ins", instruction, e.ins);
            end
        end
        @(posedge clk);
        #1;
        if (took) begin
            busy   = 1;
            wcnt   = delay;
            paddr  = a;
            grants++;
        end
        mem_rvalid = 1'b0;
        if (busy != 0) begin
            wcnt--;
            if (wcnt == 0) begin
                busy       = 0;
                mem_rvalid = 1'b1;
                mem_rdata  = word(paddr);
            end
        end
        mem_gnt = mem_req && !rst && busy == 0 && !mem_rvalid;
    endtask

    task automatic run_until_empty(input int max);
        int k = 0;
        while (q.size() > 0 && k < max) begin
            cycle();
            k++;
        end
        chk("drain_left", q.size(), 0);
        q.delete();
        ready = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        ready    = 1'b0;
        cycle();
        cycle();
        busy       = 0;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
        rows = '{
            '{32'h0000_0100, 3, 1, 1'b0, 32'h0000_0100},
            '{32'h0000_0202, 1, 0, 1'b1, 32'h0000_0200},
            '{32'hFFFF_FFFC, 1, 0, 1'b0, 32'hFFFF_FFFC},
            '{32'h0000_1003, 2, 0, 1'b1, 32'h0000_1000},
            '{32'h0000_0104, 3, 2, 1'b0, 32'h0000_0104}
        };

        // reset values, then zero-wait streaming
        do_reset();
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", valid, 0);
        chk("rst_ins", instruction, 0);
        chk("rst_pc", pc, 0);
        chk("rst_mis", misaligned, 0);
        delay = 1;
        ready = 1'b1;
        rst   = 1'b0;
        for (int i = 0; i < 4; i++) expect_pc(32'(i * 4));
        cycle();
        chk("req_after_rst", mem_req, 1);
        chk("valid_c1", valid, 0);
        cycle();
        chk("valid_c2", valid, 0);
        cycle();
        chk("first_valid", valid, 1);
        chk("first_pc", pc, 32'h0);
        run_until_empty(40);

        // decoder stalled: fetch stops once the buffer is full
        do_reset();
        rst    = 1'b0;
        grants = 0;
        repeat (10) cycle();
        chk("grants_full", grants, 2);
        chk("req_stalled", mem_req, 0);
        chk("valid_stalled", valid, 1);
        for (int i = 0; i < 3; i++) expect_pc(32'(i * 4));
        ready = 1'b1;
        run_until_empty(40);

        // redirects with a request outstanding
        for (int r = 0; r < 5; r++) begin
            do_reset();
            delay = rows[r].dly;
            rst   = 1'b0;
            n = 0;
            while (!mem_gnt && n < 20) begin cycle(); n++; end
            chk("gnt_seen", mem_gnt, 1);
            repeat (rows[r].skip) cycle();
            redirect    = 1'b1;
            redirect_pc = rows[r].tgt;
            q.delete();
            expect_pc(rows[r].pc0);
            expect_pc(rows[r].pc0 + 32'd4);
            cycle();
            redirect = 1'b0;
            chk("misaligned", misaligned, rows[r].mis);
            chk("flush_valid", valid, 0);
            cycle();
            chk("mis_pulse", misaligned, 0);
            n = 0;
            while (!mem_req && n < 20) begin cycle(); n++; end
            chk("redir_addr", mem_addr, rows[r].pc0);
            ready = 1'b1;
            run_until_empty(40);
        end

        // redirect coinciding with rvalid and a pop
        do_reset();
        delay = 1;
        rst   = 1'b0;
        n = 0;
        while (!(mem_rvalid && valid) && n < 30) begin cycle(); n++; end
        chk("overlap_seen", {31'b0, mem_rvalid && valid}, 1);
        ready       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        q.delete();
        expect_pc(32'h40);
        expect_pc(32'h44);
        cycle();
        redirect = 1'b0;
        chk("flush_pop_valid", valid, 0);
        chk("flush_pop_mis", misaligned, 0);
        run_until_empty(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Generates PCs, reads instruction words from instruction memory over a request/grant/response interface, and buffers them in a small FIFO.
- Presents {pc, instruction} pairs to the decoder with a valid/ready handshake.
- Accepts redirects (taken branches/jumps) from execute. A redirect flushes buffered and in-flight fetches.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.
- BUF_DEPTH, 2, instruction FIFO entries; power of two, ≥2.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- o_mem_req  out  1  fetch request valid.
- o_mem_addr  out  XLEN  fetch word address, always [1:0]=0.
- i_mem_gnt  in  1  memory accepts request this cycle.
- i_mem_rvalid  in  1  read data valid; arrives ≥1 cycle after gnt, in order.
- i_mem_rdata  in  XLEN  instruction word.
- i_redirect  in  1  one-cycle redirect strobe from execute.
- i_redirect_pc  in  XLEN  redirect target.
- o_misaligned  out  1  one-cycle pulse: redirect target had [1:0]≠0.
- o_valid  out  1  decoder output holds a valid instruction.
- o_instruction  out  XLEN  instruction at FIFO head.
- o_pc  out  XLEN  PC of o_instruction.
- i_ready  in  1  decoder consumes head this cycle when o_valid=1.

Behaviour:
- Reset values: o_mem_req=0, o_mem_addr=RESET_PC, o_valid=0, o_instruction=0, o_pc=0, o_misaligned=0. FIFO empty, fetch_pc=RESET_PC, state=IDLE, discard=0.
- Memory is reset together with this block. No response may be in flight across reset.
- FSM states:
  - IDLE: if count+outstanding < BUF_DEPTH and no redirect this cycle → REQ.
  - REQ: o_mem_req=1, o_mem_addr=fetch_pc, both held stable until i_mem_gnt. On gnt → WAIT, outstanding=1.
  - WAIT: on i_mem_rvalid, if discard=0, push {fetch_pc, i_mem_rdata}, fetch_pc+=4, outstanding=0. Then go to REQ if room remains after the push, else IDLE. If discard=1, drop the data, clear discard, set outstanding=0, go to IDLE.
- At most one request outstanding.
- Request issue is gated so a push never targets a full FIFO.
- fetch_pc arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 = 0.
- FIFO output:
  - o_valid = (count≠0), registered.
  - o_instruction/o_pc show the head entry.
  - Pop on o_valid&&i_ready.
  - Push and pop in the same cycle leave count unchanged.
- Latency:
  - req with gnt in cycle N, rvalid in N+1 → o_valid=1 in N+2 when the FIFO was empty.
  - After reset, o_mem_req rises in the first cycle after i_reset deasserts.
- Redirect (i_redirect=1 in cycle R), taking effect at the R edge:
  - FIFO flushed; o_valid=0 in R+1. Redirect dominates any same-cycle pop or push.
  - fetch_pc = {i_redirect_pc[XLEN-1:2],2'b00}.
  - o_misaligned=1 in R+1 iff i_redirect_pc[1:0]≠0.
  - If a request is outstanding (WAIT, or REQ with gnt in R) and rvalid does not arrive in R, set discard=1 and go to WAIT.
  - If rvalid arrives in cycle R, drop its data; no discard needed; go to REQ.
  - If in REQ without gnt, drop the pending request: go to REQ with the new address from R+1.
  - Otherwise go to REQ.
- Back-to-back redirects: the latest one wins. discard stays 1 while a response is still pending.
- o_mem_addr changes only when o_mem_req=0, after a gnt, or on redirect.

Test Plan:
- Reset, zero-wait memory (gnt immediately, rvalid next cycle), i_ready=1 → o_pc sequence 0,4,8,12 with matching rdata; first o_valid 3 cycles after reset release.
- i_ready=0 for 10 cycles → exactly BUF_DEPTH=2 words fetched, then o_mem_req=0; raise i_ready → PCs 0,4,8 emitted with no gap or duplicate.
- Redirect to 32'h0000_0100 while a request is outstanding (rvalid delayed 3 cycles) → stale word dropped, FIFO flushed, next o_pc=0x100, o_misaligned=0.
- Redirect to 32'h0000_0202 → o_misaligned pulses 1 cycle, next o_mem_addr=0x200, o_pc=0x200.
- Redirect to 32'hFFFF_FFFC → o_pc 0xFFFF_FFFC then 0x0000_0000.
- Redirect asserted in the same cycle as rvalid and i_ready pop → that word is not emitted, o_valid=0 next cycle, fetch resumes at the target.
